// File: rtl/vector_checker.sv
// Vector-table checker: replays stored stimulus into a DUT and compares its outputs under a care mask.
// Latency: vector k drives dut_in k+1 cycles after start, and is compared LAT+1 cycles after that.
// Backpressure: none; start and load_we are dropped while busy, one vector is issued per cycle.
module vector_checker #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 3,
    parameter int DEPTH = 256,
    parameter int LAT   = 0,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_we,
    input  logic [AW-1:0]           load_addr,
    input  logic [IN_W+2*OUT_W-1:0] load_data,
    input  logic [AW:0]             num_vec,
    input  logic                    start,
    input  logic                    stop_on_err,
    output logic [IN_W-1:0]         dut_in,
    input  logic [OUT_W-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        vec_count,
    output logic                    first_err_valid,
    output logic [AW-1:0]           first_err_idx,
    output logic [OUT_W-1:0]        first_err_got
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int MW = IN_W + 2*OUT_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      ADDR_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [MW-1:0]    mem [DEPTH];
    logic [MW-1:0]    rd_word;
    logic [AW:0]      rd_addr;
    logic [AW:0]      num_q;
    logic             stop_q;
    logic             accept_cfg;
    logic             rd_last;
    logic             cmp_vld;
    logic             mism;
    logic             finish;

    // Compare pipeline: stage 0 is loaded at issue, stage LAT lines up with dut_out.
    logic [LAT:0]     pv;
    logic [LAT:0]     plast;
    logic [OUT_W-1:0] pexp  [LAT+1];
    logic [OUT_W-1:0] pcare [LAT+1];
    logic [AW-1:0]    pidx  [LAT+1];

    assign accept_cfg = (state == S_IDLE) || (state == S_DONE);
    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign pass       = done && (err_count == '0);

    assign rd_word = mem[rd_addr[AW-1:0]];
    assign rd_last = (rd_addr == num_q - ADDR_ONE);
    assign cmp_vld = pv[LAT];
    assign mism    = cmp_vld && (((dut_out ^ pexp[LAT]) & pcare[LAT]) != '0);
    assign finish  = cmp_vld && (plast[LAT] || (mism && stop_q));

    always_ff @(posedge clk) begin
        if (load_we && accept_cfg) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            rd_addr         <= '0;
            num_q           <= '0;
            stop_q          <= 1'b0;
            dut_in          <= '0;
            err_count       <= '0;
            vec_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_got   <= '0;
            pv              <= '0;
            plast           <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pexp[i]  <= '0;
                pcare[i] <= '0;
                pidx[i]  <= '0;
            end
        end else begin
            pv[0] <= 1'b0;
            for (int i = 1; i <= LAT; i++) begin
                pv[i]    <= pv[i-1];
                plast[i] <= plast[i-1];
                pexp[i]  <= pexp[i-1];
                pcare[i] <= pcare[i-1];
                pidx[i]  <= pidx[i-1];
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count       <= '0;
                        vec_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        first_err_got   <= '0;
                        num_q           <= num_vec;
                        stop_q          <= stop_on_err;
                        rd_addr         <= '0;
                        state           <= (num_vec == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    dut_in   <= rd_word[MW-1 -: IN_W];
                    pv[0]    <= 1'b1;
                    plast[0] <= rd_last;
                    pexp[0]  <= rd_word[2*OUT_W-1 -: OUT_W];
                    pcare[0] <= rd_word[OUT_W-1:0];
                    pidx[0]  <= rd_addr[AW-1:0];
                    rd_addr  <= rd_addr + ADDR_ONE;
                    if (rd_last) begin
                        state <= S_DRAIN;
                    end
                end
                default: ;
            endcase

            if (cmp_vld) begin
                vec_count <= vec_count + CNT_ONE;
                if (mism) begin
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_ONE;
                    end
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= pidx[LAT];
                        first_err_got   <= dut_out;
                    end
                end
            end

            // Completion (or an early stop) overrides any issue made on the same edge.
            if (finish) begin
                state <= S_DONE;
                pv    <= '0;
            end
        end
    end

endmodule
